// File: rtl/up_down_counter.sv
// up_down_counter: free-running modulo-2^WIDTH binary counter.
// Direction is chosen every clock edge by mode_i (1 = up, 0 = down).
// Both directions wrap silently. rst_i is an asynchronous, active-low clear.
// counter_o comes straight from the count register, so there is no
// combinational path from any input to the output.
module up_down_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             mode_i,
    output logic [WIDTH-1:0] counter_o
);

    // A single step of the count. Unsigned WIDTH-bit arithmetic drops the
    // carry or borrow, so 2^WIDTH-1 wraps to 0 and 0 wraps to 2^WIDTH-1.
    localparam logic [WIDTH-1:0] COUNT_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] COUNT_ZERO = WIDTH'(0);

    // Returns the count that follows 'value' in the requested direction.
    function automatic logic [WIDTH-1:0] step_count(
        input logic [WIDTH-1:0] value,
        input logic             up
    );
        logic [WIDTH-1:0] result;
        if (up) begin
            result = value + COUNT_ONE;
        end else begin
            result = value - COUNT_ONE;
        end
        return result;
    endfunction

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] next_count_s;

    // Next count: there is no hold state, so every edge advances by one.
    always_comb begin
        next_count_s = count_r;
        case (mode_i)
            1'b1:    next_count_s = step_count(count_r, 1'b1);
            1'b0:    next_count_s = step_count(count_r, 1'b0);
            default: next_count_s = COUNT_ZERO;
        endcase
    end

    // Count register: cleared as soon as rst_i falls, and it advances on each rising edge otherwise.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_r <= COUNT_ZERO;
        end else begin
            count_r <= next_count_s;
        end
    end

    assign counter_o = count_r;

endmodule

// File: tb/tb_up_down_counter.sv
// Self-checking bench for up_down_counter (WIDTH = 3).
// The expected count is kept as a plain integer, stepped with modulo
// arithmetic from the counting rules, and compared after every edge.
module tb_up_down_counter;

    localparam int WIDTH = 3;
    localparam int MOD   = 1 << WIDTH;

    logic             clk_i;
    logic             rst_i;
    logic             mode_i;
    logic [WIDTH-1:0] counter_o;

    int checks;
    int failures;
    int exp_count;

    up_down_counter #(.WIDTH(WIDTH)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .mode_i    (mode_i),
        .counter_o (counter_o)
    );

    // 10-unit clock period, with rising edges at 5, 15, 25, ...
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input int expv);
        logic [WIDTH-1:0] e;
        e = expv[WIDTH-1:0];
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
        end
    endtask

    // Drive the direction, take one edge, then step the model and compare.
    task automatic step(input logic m, input string tag);
        mode_i = m;
        @(posedge clk_i);
        #1;
        if (m) exp_count = (exp_count + 1) % MOD;
        else   exp_count = (exp_count + MOD - 1) % MOD;
        check(tag, counter_o, exp_count);
    endtask

    // Take one edge with reset held low; the count must stay at 0.
    task automatic reset_edge(input logic m, input string tag);
        mode_i = m;
        @(posedge clk_i);
        #1;
        exp_count = 0;
        check(tag, counter_o, exp_count);
    endtask

    // Assert reset between edges, then release it well before the next edge.
    task automatic mid_cycle_reset(input string tag);
        #3;
        rst_i = 1'b0;
        #1;
        exp_count = 0;
        check(tag, counter_o, exp_count);
        #2;
        rst_i = 1'b1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        exp_count = 0;
        rst_i     = 1'b0;
        mode_i    = 1'b1;

        // Power-up reset: the count stays at 0 across edges while in reset.
        #1;
        check("reset_initial", counter_o, 0);
        reset_edge(1'b1, "reset_edge1");
        reset_edge(1'b1, "reset_edge2");

        // Release reset away from the clock edge.
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("release_no_edge", counter_o, 0);

        // Up count with wrap: 1,2,3,4,5,6,7,0,1,2.
        for (int i = 0; i < 10; i++) step(1'b1, "up_wrap");
        check("up_end_2", counter_o, 2);

        // Down count with wrap: 1,0,7,6,5,4,3,2,1,0.
        for (int i = 0; i < 10; i++) step(1'b0, "down_wrap");
        check("down_end_0", counter_o, 0);

        // Alternating blocks of 10 up and 10 down for 50 edges.
        for (int i = 0; i < 50; i++) step(((i / 10) % 2) == 0, "alternate");

        // Count up until the count reaches 5, using a bounded number of edges.
        for (int i = 0; i < MOD && exp_count != 5; i++) step(1'b1, "seek_5");
        check("at_5", counter_o, 5);

        // Async reset at 5: the output must clear before the next edge.
        #3;
        rst_i = 1'b0;
        #1;
        exp_count = 0;
        check("async_clear", counter_o, exp_count);
        reset_edge(1'b1, "held_in_reset");
        #4;
        mode_i = 1'b0;
        rst_i  = 1'b1;
        step(1'b0, "release_down");
        check("release_down_7", counter_o, 7);

        // Single-edge flip at count 3: the sequence is 2, then 3.
        for (int i = 0; i < MOD && exp_count != 3; i++) step(1'b1, "seek_3");
        check("at_3", counter_o, 3);
        step(1'b0, "flip_down");
        check("flip_down_2", counter_o, 2);
        step(1'b1, "flip_up");
        check("flip_up_3", counter_o, 3);

        // Random directions with occasional mid-cycle resets.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(1, 0)), "random_step");
            if ($urandom_range(19, 0) == 0) mid_cycle_reset("random_reset");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
